// File: rtl/gpio_arb.sv
// gpio_arb: two-requester round-robin arbiter in front of the single-ported
// GPIO register block. A granted command is captured into registers that
// drive the GPIO port for exactly one cycle. The read data is latched back
// to the winning requester together with a one-cycle ack.
module gpio_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             we0,
    input  logic [1:0]       a0,
    input  logic [WIDTH-1:0] wd0,
    output logic [WIDTH-1:0] rd0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [1:0]       a1,
    input  logic [WIDTH-1:0] wd1,
    output logic [WIDTH-1:0] rd1,
    output logic             ack1,
    output logic             g_we,
    output logic [1:0]       g_a,
    output logic [WIDTH-1:0] g_wd,
    input  logic [WIDTH-1:0] g_rd,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state;
    logic   last;     // last-served requester; the other one wins a tie
    logic   sel;      // requester owning the transaction in flight
    logic   gnt_valid;
    logic   gnt_sel;

    // Grant decision for the IDLE cycle: a lone request wins outright, and a tie goes to the requester not served last.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_sel   = (req0 && req1) ? ~last : req1;
    end

    // Arbitration FSM. The g_* registers are the captured command, so the
    // GPIO port only ever sees registered values. They are non-zero only
    // during ACCESS.
    // NOTE: every register here, including the GPIO-facing command, is
    // cleared by the asynchronous reset. The port therefore goes quiet the
    // instant rst falls, even in the middle of an ACCESS cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            sel   <= 1'b0;
            g_we  <= 1'b0;
            g_a   <= '0;
            g_wd  <= '0;
            busy  <= 1'b0;
            rd0   <= '0;
            rd1   <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge values of state, last and the g_* registers.
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        sel   <= gnt_sel;
                        last  <= gnt_sel;
                        g_we  <= gnt_sel ? we1 : we0;
                        g_a   <= gnt_sel ? a1  : a0;
                        g_wd  <= gnt_sel ? wd1 : wd0;
                        busy  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // g_rd still shows the pre-write contents on this edge.
                    if (sel) begin
                        rd1  <= g_rd;
                        ack1 <= 1'b1;
                    end else begin
                        rd0  <= g_rd;
                        ack0 <= 1'b1;
                    end
                    g_we  <= 1'b0;
                    g_a   <= '0;
                    g_wd  <= '0;
                    state <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    g_we  <= 1'b0;
                    g_a   <= '0;
                    g_wd  <= '0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_arb.sv
// Bench for gpio_arb. A small GPIO model answers the port. Address 0 is the
// input register (gin). Addresses 1..3 are output registers that clear on
// reset. Single-requester transactions come from a vector table. Ties,
// alternation, back-to-back requests and reset in the middle of a
// transaction are written out as hand sequences.
module tb_gpio_arb;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, we0, req1, we1;
    logic [1:0]       a0, a1;
    logic [WIDTH-1:0] wd0, wd1, rd0, rd1;
    logic             ack0, ack1;
    logic             g_we;
    logic [1:0]       g_a;
    logic [WIDTH-1:0] g_wd, g_rd;
    logic             busy;

    logic [WIDTH-1:0] gin;
    logic [WIDTH-1:0] mem [0:3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_arb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .a0(a0), .wd0(wd0), .rd0(rd0), .ack0(ack0),
        .req1(req1), .we1(we1), .a1(a1), .wd1(wd1), .rd1(rd1), .ack1(ack1),
        .g_we(g_we), .g_a(g_a), .g_wd(g_wd), .g_rd(g_rd), .busy(busy)
    );

    // GPIO register block model: write on the clock edge, combinational read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (g_we && g_a != 2'd0) begin
            mem[g_a] <= g_wd;
        end
    end

    assign g_rd = (g_a == 2'd0) ? gin : mem[g_a];

    function automatic logic [WIDTH-1:0] model_read(input logic [1:0] a);
        return (a == 2'd0) ? gin : mem[a];
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic             who;
        logic             we;
        logic [1:0]       a;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] gin;
        logic [WIDTH-1:0] exp_rd;
        logic [WIDTH-1:0] exp_after;
    } vec_t;

    vec_t vecs [8];
    logic [WIDTH-1:0] exp_rd0, exp_rd1;

    initial begin
        // who, we, a, wd, gin, expected rd (pre-write value), expected register afterwards
        vecs[0] = '{1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h00000000, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 2'd2, 32'h0BAD0BAD, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, 32'h0,        32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b0, 1'b1, 2'd1, 32'h0000FFFF, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};

        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
        gin = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;

        // Reset values, before any clock edge
        #1;
        check("rst_g_we", g_we, 0);
        check("rst_g_a", g_a, 0);
        check("rst_g_wd", g_wd, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {ack0, ack1}, 0);
        check("rst_rd0", rd0, 0);
        check("rst_rd1", rd1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table: one requester per transaction, the other one idle with junk inputs
        for (int i = 0; i < 8; i++) begin
            gin = vecs[i].gin;
            if (vecs[i].who) begin
                req1 = 1'b1; we1 = vecs[i].we; a1 = vecs[i].a; wd1 = vecs[i].wd;
                req0 = 1'b0; we0 = ~vecs[i].we; a0 = ~vecs[i].a; wd0 = ~vecs[i].wd;
            end else begin
                req0 = 1'b1; we0 = vecs[i].we; a0 = vecs[i].a; wd0 = vecs[i].wd;
                req1 = 1'b0; we1 = ~vecs[i].we; a1 = ~vecs[i].a; wd1 = ~vecs[i].wd;
            end
            @(negedge clk); // ACCESS
            check($sformatf("v%0d_acc_we", i), g_we, vecs[i].we);
            check($sformatf("v%0d_acc_a", i), g_a, vecs[i].a);
            check($sformatf("v%0d_acc_wd", i), g_wd, vecs[i].wd);
            check($sformatf("v%0d_acc_acks", i), {busy, ack0, ack1}, 3'b100);
            @(negedge clk); // ACK
            check($sformatf("v%0d_ack", i), {ack0, ack1}, vecs[i].who ? 2'b01 : 2'b10);
            check($sformatf("v%0d_ack_port", i), {g_we, g_a}, 0);
            if (vecs[i].who) exp_rd1 = vecs[i].exp_rd;
            else             exp_rd0 = vecs[i].exp_rd;
            check($sformatf("v%0d_rd0", i), rd0, exp_rd0);
            check($sformatf("v%0d_rd1", i), rd1, exp_rd1);
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk); // IDLE
            check($sformatf("v%0d_idle", i), {busy, ack0, ack1}, 0);
            check($sformatf("v%0d_reg", i), model_read(vecs[i].a), vecs[i].exp_after);
        end

        // Tie straight after reset: requester 0 first, then 1
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        gin = '0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; a0 = 2'd2; wd0 = 32'h1;
        req1 = 1'b1; we1 = 1'b1; a1 = 2'd2; wd1 = 32'h2;
        @(negedge clk);
        check("tie_first_wd", g_wd, 32'h1);
        @(negedge clk);
        check("tie_first_ack", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        @(negedge clk);
        check("tie_gap_busy", busy, 0);
        @(negedge clk);
        check("tie_second_wd", g_wd, 32'h2);
        @(negedge clk);
        check("tie_second_ack", {ack0, ack1}, 2'b01);
        req1 = 1'b0;
        @(negedge clk);
        check("tie_reg", mem[2], 32'h2);

        // Both held for six transactions: strict alternation, starting with 0
        gin = 32'h600DF00D;
        req0 = 1'b1; we0 = 1'b0; a0 = 2'd0; wd0 = '0;
        req1 = 1'b1; we1 = 1'b0; a1 = 2'd0; wd1 = '0;
        for (int k = 0; k < 18; k++) begin
            logic [2:0] exp_sig;
            @(negedge clk);
            exp_sig[2] = (k % 3) != 2;
            exp_sig[1] = (k % 6) == 1;
            exp_sig[0] = (k % 6) == 4;
            check($sformatf("alt_k%0d", k), {busy, ack0, ack1}, exp_sig);
            if (k == 16) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check("alt_rd0", rd0, 32'h600DF00D);
        check("alt_rd1", rd1, 32'h600DF00D);

        // req0 held through its ack, with new address/data presented during ACK
        req0 = 1'b1; we0 = 1'b1; a0 = 2'd1; wd0 = 32'h11111111;
        @(negedge clk);
        check("hold_acc1", {g_we, g_a}, 3'b101);
        check("hold_acc1_wd", g_wd, 32'h11111111);
        @(negedge clk);
        check("hold_ack1", {ack0, ack1}, 2'b10);
        a0 = 2'd3; wd0 = 32'h22222222;
        @(negedge clk);
        check("hold_gap", {busy, g_we}, 0);
        check("hold_reg1", mem[1], 32'h11111111);
        @(negedge clk);
        check("hold_acc2", {g_we, g_a}, 3'b111);
        check("hold_acc2_wd", g_wd, 32'h22222222);
        @(negedge clk);
        check("hold_ack2", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        @(negedge clk);
        check("hold_reg3", mem[3], 32'h22222222);
        check("hold_reg1_kept", mem[1], 32'h11111111);

        // Reset asserted in the middle of an ACCESS write
        req0 = 1'b1; we0 = 1'b1; a0 = 2'd2; wd0 = 32'h55555555;
        @(posedge clk);
        #1;
        check("mid_pre_we", g_we, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we", g_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_acks", {ack0, ack1}, 0);
        check("mid_rst_a", g_a, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mid_after_k%0d", k), {busy, g_we, ack0, ack1}, 0);
        end
        check("mid_reg", mem[2], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_arb.md
Name: gpio_arb

Overview:
Two-requester round-robin arbiter that shares the single-ported GPIO register block (we / a / wd / rd interface) between two bus masters, e.g. the CPU data port and a debug/DMA master. Each requester runs a req/ack handshake. The arbiter registers the winning command, drives it onto the GPIO port for exactly one cycle, captures the read data and returns a one-cycle ack. It sits between the masters' address decode and the GPIO block.

Parameters:
WIDTH, 32, data width of wd/rd paths (matches the GPIO block width)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
req0  input  1  requester 0 transaction request
we0  input  1  requester 0 write enable (1 = write, 0 = read)
a0  input  2  requester 0 GPIO register address
wd0  input  WIDTH  requester 0 write data
rd0  output  WIDTH  requester 0 read data, valid while ack0 = 1
ack0  output  1  requester 0 completion pulse
req1, we1, a1, wd1, rd1, ack1  same as above for requester 1
g_we  output  1  GPIO write enable
g_a  output  2  GPIO address
g_wd  output  WIDTH  GPIO write data
g_rd  input  WIDTH  GPIO read data (combinational from the GPIO block)
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; last-served pointer = 1, so requester 0 wins the first tie. Captured command registers, rd0, rd1, ack0 and ack1 all reset to 0. g_we, g_a, g_wd and busy are 0 immediately, with no clock edge needed.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - req sampled on the rising edge.
  - If exactly one req is 1, that requester is granted.
  - If both are 1, grant the requester that is not the last-served pointer.
  - On a grant: latch sel, we_x, a_x and wd_x into the command registers; update the pointer to sel; go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - g_a = captured a; g_wd = captured wd; g_we = captured we.
  - The GPIO register write occurs on the edge that ends ACCESS.
  - On that same edge, g_rd is latched into rd_sel; for a write, rd_sel is loaded with g_rd at the captured address, i.e. the pre-write value.
  - ack_sel is set; go to ACK.
- ACK (exactly 1 cycle):
  - ack_sel = 1 and the other ack = 0.
  - req inputs are ignored in this state.
  - Next state is IDLE. ack clears on the edge leaving ACK.
- Outside ACCESS: g_we = 0, g_a = 0, g_wd = 0. The GPIO port is never driven with uncaptured requester inputs.
- rd0 and rd1 hold their last value until overwritten by that requester's next transaction.
- Latency: req high at edge N → ACCESS in cycle N..N+1 → ack high in cycle N+1..N+2. Minimum period is 3 cycles per transaction, including the mandatory IDLE cycle.
- Handshake rules:
  - Requester holds req, we, a and wd stable until it is granted; only the values at the grant edge matter.
  - Requester deasserts req by the edge ending its ack cycle.
  - req still high in the following IDLE cycle is a new transaction.
- Fairness: with both reqs held continuously, grants strictly alternate 0,1,0,1. Neither requester waits more than one transaction.
- A req that drops before being granted is simply not served; there is no state kept.
- Reset mid-transaction:
  - Asserting rst during ACCESS drops g_we asynchronously, and no ack is produced.
  - The pending transaction is lost; the requester must re-issue it after reset.
- Only ack0 or ack1 can be 1 in any cycle, never both. g_we = 1 implies busy = 1.

Test Plan:
- Reset, then req0 = 1, we0 = 1, a0 = 2, wd0 = 0xDEADBEEF for 1 cycle → g_we = 1 for exactly one cycle with g_a = 2; ack0 = 1 two cycles after the req edge; GPIO output reg 1 reads 0xDEADBEEF; ack1 = 0 throughout.
- g_rd source GPIO input 1 = 0x12345678; req1 = 1, we1 = 0, a1 = 0 → g_we stays 0; rd1 = 0x12345678 while ack1 = 1; rd0 is unchanged.
- Immediately after reset, req0 and req1 both asserted as writes (a = 2, wd = 0x1 and 0x2), each dropping its req after its own ack → requester 0 is served first, then requester 1; output reg 1 ends at 0x2.
- req0 and req1 held high continuously for 6 transactions → ack sequence 0,1,0,1,0,1; each ack is 3 cycles apart; busy = 0 for exactly one cycle between transactions.
- rst driven to 0 mid-cycle while in ACCESS with a write pending → g_we, busy and the acks go 0 without a clock edge; after release the FSM is in IDLE and the GPIO register holds its reset value.
- req0 held high through its ack with a new address → a second, distinct transaction starts from the following IDLE cycle; a0/wd0 changes made while in ACK do not affect the first transaction.
